id_stall_sequencer: RTL and testbench

//  Pipeline-stall controller beside the decode stage. Decides each cycle whether ID issues its instruction
//  to EXE or a NOP bubble, and whether fetch freezes. Covers load-use hazards and syscall/LL/SC drains.
//  A syscall drain freezes fetch, lets older instructions retire, then pulses SYS to the simulator.
//  It then releases fetch. Replaces the ad-hoc bubble counter inside decode.

---
 rtl/id_stall_sequencer_pkg.sv | 26 ++
 rtl/id_stall_sequencer_hazard_detect.sv | 27 ++
 rtl/id_stall_sequencer.sv | 129 ++++++++++++
 tb/tb_id_stall_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/id_stall_sequencer_pkg.sv
// rtl/id_stall_sequencer_pkg.sv - shared stall-sequencer types and ALU control constants
//
// Purpose: state encoding for the ID stall sequencer plus the LL/SC ALU
//          control codes that the decoder and MEM stage also use.
// Ports:   none (package).

package id_stall_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_LU_STALL  = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_SYS_PULSE = 3'd3,
    ST_RESUME    = 3'd4
  } state_t;

  localparam int unsigned CNT_W  = 3;
  localparam logic [5:0]  ALU_LL = 6'b101000;
  localparam logic [5:0]  ALU_SC = 6'b110110;

  // LL/SC drain the pipeline like a syscall but the simulator is not called.
  function automatic logic is_ll_sc(input logic [5:0] alu_ctrl);
    return (alu_ctrl == ALU_LL) || (alu_ctrl == ALU_SC);
  endfunction

endpackage

// File: rtl/id_stall_sequencer_hazard_detect.sv
// rtl/id_stall_sequencer_hazard_detect.sv - combinational EXE-load to ID-use hazard compare
//
// Purpose: flags an instruction in ID that reads the destination of a load
//          currently in EXE. Register $0 never creates a hazard.
// Ports:   id_valid       in  ID holds a real instruction
//          id_reg_a/b     in  source registers read by ID (0 = unused)
//          exe_mem_read   in  EXE instruction is a load
//          exe_write_reg  in  destination of EXE instruction
//          loaduse        out hazard present (forced 0 when EN=0)

module hazard_detect #(
  parameter bit EN = 1'b1
) (
  input  logic       id_valid,
  input  logic [4:0] id_reg_a,
  input  logic [4:0] id_reg_b,
  input  logic       exe_mem_read,
  input  logic [4:0] exe_write_reg,
  output logic       loaduse
);

  logic reg_match;

  assign reg_match = (exe_write_reg == id_reg_a) || (exe_write_reg == id_reg_b);
  assign loaduse   = EN && id_valid && exe_mem_read && (exe_write_reg != 5'd0) && reg_match;

endmodule

// File: rtl/id_stall_sequencer.sv
// rtl/id_stall_sequencer.sv - decode-stage stall controller for load-use and syscall/LL/SC drains
//
// Purpose: each cycle decides whether ID issues to EXE or sends a bubble, and
//          whether fetch freezes. A syscall drain freezes fetch, lets older
//          instructions retire, pulses SYS to the simulator, then releases.
// Ports:   CLK, RESET (async, active-low)
//          ID_Valid, ID_Syscall, ID_ALUControl, ID_RegA, ID_RegB  in  ID instruction
//          EXE_MemRead, EXE_WriteReg                               in  EXE instruction
//          WANT_FREEZE, ID_BUBBLE, ID_PASS_SYS                     out combinational
//          SYS, BUSY                                               out registered

module id_stall_sequencer
  import id_stall_sequencer_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter bit          LOADUSE_EN   = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ID_Valid,
  input  logic       ID_Syscall,
  input  logic [5:0] ID_ALUControl,
  input  logic [4:0] ID_RegA,
  input  logic [4:0] ID_RegB,
  input  logic       EXE_MemRead,
  input  logic [4:0] EXE_WriteReg,
  output logic       WANT_FREEZE,
  output logic       ID_BUBBLE,
  output logic       ID_PASS_SYS,
  output logic       SYS,
  output logic       BUSY
);

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 7) begin : g_bad_drain_cycles
    $error("id_stall_sequencer: DRAIN_CYCLES must be 1..7");
  end

  localparam logic [CNT_W-1:0] DRAIN_M1 = CNT_W'(DRAIN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       alu_q, alu_d;
  logic             sys_q, sys_d;
  logic             busy_q, busy_d;
  logic             freeze, bubble, pass_sys;
  logic             loaduse;

  hazard_detect #(
    .EN (LOADUSE_EN)
  ) u_hazard_detect (
    .id_valid      (ID_Valid),
    .id_reg_a      (ID_RegA),
    .id_reg_b      (ID_RegB),
    .exe_mem_read  (EXE_MemRead),
    .exe_write_reg (EXE_WriteReg),
    .loaduse       (loaduse)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_d    = alu_q;
    freeze   = 1'b0;
    bubble   = 1'b0;
    pass_sys = 1'b0;
    case (state_q)
      ST_RUN: begin
        // Syscall wins over a simultaneous load-use hazard.
        if (ID_Valid && ID_Syscall) begin
          freeze   = 1'b1;
          bubble   = 1'b1;
          pass_sys = 1'b1;
          cnt_d    = DRAIN_M1;
          alu_d    = ID_ALUControl;
          state_d  = (DRAIN_CYCLES == 1) ? ST_SYS_PULSE : ST_DRAIN;
        end else if (loaduse) begin
          freeze  = 1'b1;
          bubble  = 1'b1;
          state_d = ST_LU_STALL;
        end
      end
      // Load has moved to MEM; forwarding covers the use, so no second stall.
      ST_LU_STALL: state_d = ST_RUN;
      ST_DRAIN: begin
        freeze = 1'b1;
        bubble = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_SYS_PULSE;
      end
      ST_SYS_PULSE: begin
        freeze  = 1'b1;
        bubble  = 1'b1;
        state_d = ST_RESUME;
      end
      // Fetch released; the held syscall in ID retires as a bubble.
      ST_RESUME: begin
        bubble  = 1'b1;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    sys_d  = (state_d == ST_SYS_PULSE) && (state_q != ST_SYS_PULSE) && !is_ll_sc(alu_d);
    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      alu_q   <= '0;
      sys_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alu_q   <= alu_d;
      sys_q   <= sys_d;
      busy_q  <= busy_d;
    end
  end

  // Held in reset, RUN decoding must not leak a syscall/hazard request out.
  assign WANT_FREEZE = freeze && RESET;
  assign ID_BUBBLE   = bubble && RESET;
  assign ID_PASS_SYS = pass_sys && RESET;
  assign SYS         = sys_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_id_stall_sequencer.sv
// tb/tb_id_stall_sequencer.sv - self-checking bench for id_stall_sequencer

module tb_id_stall_sequencer;

  localparam int D = 3;

  logic       CLK;
  logic       RESET;
  logic       ID_Valid;
  logic       ID_Syscall;
  logic [5:0] ID_ALUControl;
  logic [4:0] ID_RegA;
  logic [4:0] ID_RegB;
  logic       EXE_MemRead;
  logic [4:0] EXE_WriteReg;
  logic       WANT_FREEZE;
  logic       ID_BUBBLE;
  logic       ID_PASS_SYS;
  logic       SYS;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  id_stall_sequencer #(
    .DRAIN_CYCLES (D),
    .LOADUSE_EN   (1'b1)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .ID_Valid      (ID_Valid),
    .ID_Syscall    (ID_Syscall),
    .ID_ALUControl (ID_ALUControl),
    .ID_RegA       (ID_RegA),
    .ID_RegB       (ID_RegB),
    .EXE_MemRead   (EXE_MemRead),
    .EXE_WriteReg  (EXE_WriteReg),
    .WANT_FREEZE   (WANT_FREEZE),
    .ID_BUBBLE     (ID_BUBBLE),
    .ID_PASS_SYS   (ID_PASS_SYS),
    .SYS           (SYS),
    .BUSY          (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: pos counts cycles since a syscall was accepted
  // (0 = free cycle), lu_follow marks the cycle after a load-use stall.
  int pos = 0;
  bit sys_ok = 1'b0;
  bit lu_follow = 1'b0;
  int freeze_seen = 0;
  int sys_seen = 0;
  bit ef, eb, ep, es, ebz, m_lu;

  always @(negedge CLK) begin
    ef = 0; eb = 0; ep = 0; es = 0; ebz = 0;
    m_lu = ID_Valid && EXE_MemRead && (EXE_WriteReg != 0) &&
           ((EXE_WriteReg == ID_RegA) || (EXE_WriteReg == ID_RegB));
    if (!RESET) begin
      pos = 0;
      lu_follow = 0;
    end else if (pos > 0) begin
      eb = 1; ebz = 1;
      if (pos <= D) begin
        ef = 1;
        es = (pos == D) && sys_ok;
        pos++;
      end else begin
        pos = 0;
      end
    end else if (lu_follow) begin
      ebz = 1;
      lu_follow = 0;
    end else if (ID_Valid && ID_Syscall) begin
      ef = 1; eb = 1; ep = 1;
      pos = 1;
      sys_ok = !(ID_ALUControl == 6'b101000 || ID_ALUControl == 6'b110110);
    end else if (m_lu) begin
      ef = 1; eb = 1;
      lu_follow = 1;
    end
    chk("WANT_FREEZE", int'(WANT_FREEZE), int'(ef));
    chk("ID_BUBBLE", int'(ID_BUBBLE), int'(eb));
    chk("ID_PASS_SYS", int'(ID_PASS_SYS), int'(ep));
    chk("SYS", int'(SYS), int'(es));
    chk("BUSY", int'(BUSY), int'(ebz));
    freeze_seen += int'(WANT_FREEZE);
    sys_seen += int'(SYS);
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    freeze_seen = 0;
    sys_seen = 0;
  endtask

  task automatic idle_inputs();
    ID_Valid = 0; ID_Syscall = 0; ID_ALUControl = 6'h00;
    ID_RegA = 0; ID_RegB = 0; EXE_MemRead = 0; EXE_WriteReg = 0;
  endtask

  initial begin
    RESET = 1'b1;
    idle_inputs();
    ID_Valid = 1; ID_Syscall = 1; ID_ALUControl = 6'h0c;
    #1 RESET = 1'b0;
    step(2);
    chk("reset_freeze_literal", int'(WANT_FREEZE), 0);
    chk("reset_bubble_literal", int'(ID_BUBBLE), 0);
    chk("reset_busy_literal", int'(BUSY), 0);

    // Release with syscall held: drain starts on the first edge.
    RESET = 1'b1;
    clr();
    step(1);
    idle_inputs();
    step(5);
    chk("sys_drain_freeze_cycles", freeze_seen, 4);
    chk("sys_drain_pulses", sys_seen, 1);

    // Load-use on rs: one stall cycle, then nothing even with hazard held.
    clr();
    ID_Valid = 1; ID_RegA = 5; ID_RegB = 6; EXE_MemRead = 1; EXE_WriteReg = 5;
    step(2);
    chk("loaduse_freeze_cycles", freeze_seen, 1);
    // Load into $0 never stalls.
    clr();
    ID_RegA = 0; EXE_WriteReg = 0;
    step(2);
    chk("zero_dest_freeze_cycles", freeze_seen, 0);
    // Load-use on rt.
    clr();
    ID_RegA = 3; ID_RegB = 9; EXE_WriteReg = 9;
    step(1);
    idle_inputs();
    step(1);
    chk("loaduse_rt_freeze_cycles", freeze_seen, 1);

    // LL: same freeze timing, no SYS.
    clr();
    ID_Valid = 1; ID_Syscall = 1; ID_ALUControl = 6'b101000;
    EXE_MemRead = 1; EXE_WriteReg = 7; ID_RegA = 7;
    step(1);
    idle_inputs();
    step(5);
    chk("ll_freeze_cycles", freeze_seen, 4);
    chk("ll_pulses", sys_seen, 0);

    // SC: no SYS either.
    clr();
    ID_Valid = 1; ID_Syscall = 1; ID_ALUControl = 6'b110110;
    step(1);
    idle_inputs();
    step(5);
    chk("sc_pulses", sys_seen, 0);

    // Back-to-back syscalls held in ID: two drains, two pulses.
    clr();
    ID_Valid = 1; ID_Syscall = 1; ID_ALUControl = 6'h0c;
    step(10);
    idle_inputs();
    step(2);
    chk("b2b_freeze_cycles", freeze_seen, 8);
    chk("b2b_pulses", sys_seen, 2);

    // Reset during DRAIN with cnt==1: no pulse afterwards.
    clr();
    ID_Valid = 1; ID_Syscall = 1; ID_ALUControl = 6'h0c;
    step(1);
    idle_inputs();
    step(1);
    RESET = 1'b0;
    step(2);
    RESET = 1'b1;
    step(6);
    chk("mid_reset_pulses", sys_seen, 0);
    chk("mid_reset_busy_literal", int'(BUSY), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
